// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb_pkg
// Brief    : Shared types, defaults and width helper for the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_BUSY_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4
  } state_e;

  function automatic int grant_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and UART-side signals of the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int GRANT_W = grant_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    cfg_par_en;
  logic                    cfg_par_typ;
  logic [DATA_W-1:0]       tx_p_data;
  logic                    tx_data_valid;
  logic                    tx_par_en;
  logic                    tx_par_typ;
  logic                    tx_busy;
  logic [GRANT_W-1:0]      grant_id;
  logic                    grant_active;
  logic                    timeout_err;
  logic                    err_clr;

  modport master (
    output req_valid, req_data, req_last, cfg_par_en, cfg_par_typ, tx_busy, err_clr,
    input  req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
           grant_id, grant_active, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, cfg_par_en, cfg_par_typ, tx_busy, err_clr,
    output req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
           grant_id, grant_active, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_arbiter
// Brief    : Combinational rotating-priority picker starting at rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int GRANT_W = grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic [N_REQ-1:0]   grant,
  output logic [GRANT_W-1:0] index,
  output logic               any
);

  int k;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      // Modular wrap without a divider, so N_REQ need not be a power of two
      k = int'(rr_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        index    = k[GRANT_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, message-locked sharing of one UART TX among requesters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int GRANT_W = grant_w(N_REQ);
  localparam int CNT_W   = (BUSY_TIMEOUT < 3) ? 1 : $clog2(BUSY_TIMEOUT);
  localparam logic [GRANT_W-1:0] c_LAST_ID = GRANT_W'(N_REQ - 1);
  // The pulse cycle itself counts as the first timeout cycle
  localparam logic [CNT_W-1:0]   c_TO_LAST = CNT_W'(BUSY_TIMEOUT - 2);

  state_e             r_state;
  logic [GRANT_W-1:0] r_rr_ptr;
  logic [GRANT_W-1:0] r_grant_id;
  logic               r_grant_active;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_tx_dv;
  logic               r_par_en;
  logic               r_par_typ;
  logic               r_last_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout_err;

  logic [N_REQ-1:0]   w_grant;
  logic [GRANT_W-1:0] w_idx;
  logic               w_any;
  logic [N_REQ-1:0]   w_ready;
  logic               w_xfer;
  logic [GRANT_W-1:0] w_src;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_last;
  logic [GRANT_W-1:0] w_next_ptr;

  uart_rr_arbiter #(
    .N_REQ   (N_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr (
    .req    (bus.req_valid),
    .rr_ptr (r_rr_ptr),
    .grant  (w_grant),
    .index  (w_idx),
    .any    (w_any)
  );

  // Ready is gated by reset so nothing is offered while the block is held
  always_comb begin
    w_ready = '0;
    if (reset) begin
      if (r_state == IDLE && w_any)
        w_ready = w_grant;
      else if (r_state == NEXT)
        w_ready[r_grant_id] = bus.req_valid[r_grant_id];
    end
  end

  assign w_xfer     = |(w_ready & bus.req_valid);
  assign w_src      = (r_state == NEXT) ? r_grant_id : w_idx;
  assign w_sel_data = bus.req_data[int'(w_src)*DATA_W +: DATA_W];
  assign w_sel_last = bus.req_last[w_src];
  assign w_next_ptr = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_grant_active <= 1'b0;
      r_tx_data      <= '0;
      r_tx_dv        <= 1'b0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_last_q       <= 1'b0;
      r_cnt          <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      if (bus.err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_tx_data      <= w_sel_data;
            r_last_q       <= w_sel_last;
            r_grant_id     <= w_idx;
            r_grant_active <= 1'b1;
            r_par_en       <= bus.cfg_par_en;
            r_par_typ      <= bus.cfg_par_typ;
            r_tx_dv        <= 1'b1;
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == c_TO_LAST) begin
            r_timeout_err  <= 1'b1;
            r_grant_active <= 1'b0;
            r_rr_ptr       <= w_next_ptr;
            r_state        <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (r_last_q) begin
              r_grant_active <= 1'b0;
              r_rr_ptr       <= w_next_ptr;
              r_state        <= IDLE;
            end else begin
              r_state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (w_xfer) begin
            r_tx_data <= w_sel_data;
            r_last_q  <= w_sel_last;
            r_tx_dv   <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.tx_p_data     = r_tx_data;
  assign bus.tx_data_valid = r_tx_dv;
  assign bus.tx_par_en     = r_par_en;
  assign bus.tx_par_typ    = r_par_typ;
  assign bus.grant_id      = r_grant_id;
  assign bus.grant_active  = r_grant_active;
  assign bus.timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed, table-driven bench for uart_tx_arbiter with a UART busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BT    = 16;
  localparam int FRAME = 6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // UART model: busy for FRAME cycles after each start pulse
  logic uart_en;
  int   busy_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset)                           busy_cnt <= 0;
    else if (uart_en && bus.tx_data_valid) busy_cnt <= FRAME;
    else if (busy_cnt != 0)                busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       par;
  } tx_rec_t;
  tx_rec_t log_q[$];
  always @(posedge clk) begin
    if (reset && bus.tx_data_valid)
      log_q.push_back({bus.grant_id, bus.tx_p_data, bus.tx_par_en});
  end

  logic lock_mon  = 1'b0;
  int   lock_viol = 0;
  always @(negedge clk) begin
    if (lock_mon && bus.req_ready[1]) lock_viol++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [7:0] d;
    logic       par;
    int         exp_id;
    logic [7:0] exp_byte;
  } row_t;
  row_t rows[11];

  task automatic run_row(input row_t r, input int idx);
    int n;
    bus.req_valid   = r.mask;
    bus.req_last    = '1;
    bus.cfg_par_en  = r.par;
    bus.cfg_par_typ = ~r.par;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = r.d + 8'(i);
    #1;
    n = 0;
    while (!(|(bus.req_ready & bus.req_valid)) && n < 20) begin @(posedge clk); #1; n++; end
    chk($sformatf("row%0d_ready", idx), {28'd0, bus.req_ready}, 32'(1 << r.exp_id));
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk($sformatf("row%0d_dv", idx),     {31'd0, bus.tx_data_valid}, 32'd1);
    chk($sformatf("row%0d_data", idx),   {24'd0, bus.tx_p_data}, {24'd0, r.exp_byte});
    chk($sformatf("row%0d_gid", idx),    {30'd0, bus.grant_id}, 32'(r.exp_id));
    chk($sformatf("row%0d_par", idx),    {30'd0, bus.tx_par_en, bus.tx_par_typ}, {30'd0, r.par, ~r.par});
    n = 0;
    while (bus.grant_active && n < 40) begin @(posedge clk); #1; n++; end
    chk($sformatf("row%0d_release", idx), {31'd0, bus.grant_active}, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] lb [3];
    tx_rec_t exp_log [4];

    rows[0]  = '{4'b0100, 8'hA3, 1'b1, 2, 8'hA5};
    rows[1]  = '{4'b1111, 8'h10, 1'b0, 3, 8'h13};
    rows[2]  = '{4'b1111, 8'h20, 1'b1, 0, 8'h20};
    rows[3]  = '{4'b1111, 8'h30, 1'b0, 1, 8'h31};
    rows[4]  = '{4'b1111, 8'h40, 1'b1, 2, 8'h42};
    rows[5]  = '{4'b1111, 8'h50, 1'b0, 3, 8'h53};
    rows[6]  = '{4'b1111, 8'h60, 1'b1, 0, 8'h60};
    rows[7]  = '{4'b1001, 8'h70, 1'b0, 3, 8'h73};
    rows[8]  = '{4'b0110, 8'h80, 1'b1, 1, 8'h81};
    rows[9]  = '{4'b0001, 8'h90, 1'b0, 0, 8'h90};
    rows[10] = '{4'b0010, 8'hA0, 1'b1, 1, 8'hA1};

    lb[0] = 8'h11; lb[1] = 8'h22; lb[2] = 8'h33;
    exp_log[0] = {2'd0, 8'h11, 1'b1};
    exp_log[1] = {2'd0, 8'h22, 1'b1};
    exp_log[2] = {2'd0, 8'h33, 1'b1};
    exp_log[3] = {2'd1, 8'h99, 1'b0};

    // Reset state, with requests pending so ready gating is visible
    uart_en         = 1'b1;
    bus.req_valid   = 4'b1111;
    bus.req_data    = '0;
    bus.req_last    = '1;
    bus.cfg_par_en  = 1'b0;
    bus.cfg_par_typ = 1'b0;
    bus.err_clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_dv",    {31'd0, bus.tx_data_valid}, 32'd0);
    chk("rst_act",   {31'd0, bus.grant_active}, 32'd0);
    chk("rst_err",   {31'd0, bus.timeout_err}, 32'd0);
    bus.req_valid = '0;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_row(rows[i], i);

    // Locked three-byte message from req0 while req1 waits; parity changes mid-message
    log_q.delete();
    bus.cfg_par_en  = 1'b1;
    bus.cfg_par_typ = 1'b0;
    bus.req_valid   = 4'b0011;
    bus.req_last    = 4'b0010;
    bus.req_data    = '0;
    bus.req_data[0*DW +: DW] = lb[0];
    bus.req_data[1*DW +: DW] = 8'h99;
    lock_mon = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!bus.req_ready[0] && n < 40) begin @(posedge clk); #1; n++; end
      chk($sformatf("lock_ready_b%0d", k), {28'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      bus.cfg_par_en = 1'b0;
      if (k < 2) begin
        bus.req_data[0*DW +: DW] = lb[k+1];
        bus.req_last[0] = (k == 1);
      end else begin
        bus.req_valid[0] = 1'b0;
      end
    end
    n = 0;
    while (bus.grant_active && n < 40) begin @(posedge clk); #1; n++; end
    lock_mon = 1'b0;
    chk("lock_release", {31'd0, bus.grant_active}, 32'd0);
    chk("lock_ready1",  {28'd0, bus.req_ready}, 32'd2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 0;
    while (bus.grant_active && n < 40) begin @(posedge clk); #1; n++; end
    chk("lock_viol",    32'(lock_viol), 32'd0);
    chk("lock_log_len", 32'(log_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < log_q.size()) chk($sformatf("lock_log%0d", k), {21'd0, log_q[k]}, {21'd0, exp_log[k]});
      else                  chk($sformatf("lock_log%0d", k), 32'hFFFF_FFFF, {21'd0, exp_log[k]});
    end

    // Busy never rises: timeout after BT cycles measured from the start pulse
    uart_en       = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_last  = '1;
    bus.req_data[2*DW +: DW] = 8'h5A;
    #1;
    chk("to_ready", {28'd0, bus.req_ready}, 32'd4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("to_dv", {31'd0, bus.tx_data_valid}, 32'd1);
    repeat (BT - 1) @(posedge clk);
    #1;
    chk("to_err_early", {31'd0, bus.timeout_err, bus.grant_active}, 32'b01);
    @(posedge clk); #1;
    chk("to_err_set", {31'd0, bus.timeout_err, bus.grant_active}, 32'b10);
    bus.req_valid = 4'b1001;
    #1;
    chk("to_rr_next", {28'd0, bus.req_ready}, 32'd8);
    bus.req_valid = '0;
    bus.err_clr   = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    chk("to_err_clr", {31'd0, bus.timeout_err}, 32'd0);

    // Reset asserted while req3's first byte is on the line
    uart_en        = 1'b1;
    bus.cfg_par_en = 1'b1;
    bus.req_valid  = 4'b1000;
    bus.req_last   = '0;
    bus.req_data[3*DW +: DW] = 8'h3C;
    #1;
    chk("rm_ready", {28'd0, bus.req_ready}, 32'd8);
    @(posedge clk); #1;
    bus.req_data[3*DW +: DW] = 8'h3D;
    n = 0;
    while (!bus.tx_busy && n < 20) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    chk("rm_pre", {29'd0, bus.grant_active, bus.grant_id}, 32'b111);
    reset = 1'b0;
    #1;
    chk("rm_data",  {24'd0, bus.tx_p_data}, 32'd0);
    chk("rm_flags", {27'd0, bus.tx_data_valid, bus.tx_par_en, bus.tx_par_typ, bus.grant_active, bus.timeout_err}, 32'd0);
    chk("rm_gid",   {30'd0, bus.grant_id}, 32'd0);
    chk("rm_ready", {28'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.req_valid = 4'b1001;
    bus.req_last  = '1;
    bus.req_data[0*DW +: DW] = 8'h0F;
    #1;
    chk("rm_after_ready", {28'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("rm_after_tx", {22'd0, bus.grant_id, bus.tx_p_data}, {22'd0, 2'd0, 8'h0F});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
